// File: rtl/roulette_pkg.sv
// Shared definitions for the even/odd roulette game.
// Holds the spinner state encoding, the LFSR geometry and step function, and
// the default result width/range shared with roulette_guessEvenOdd so that
// randnum widths line up across the two blocks.
package roulette_pkg;

  localparam int unsigned      LFSR_W      = 16;
  localparam logic [15:0]      LFSR_TAPS   = 16'hB400;
  localparam int unsigned      DEF_NUM_W   = 5;
  localparam int unsigned      DEF_MAX_NUM = 31;

  typedef enum logic {
    IDLE = 1'b0,
    SPIN = 1'b1
  } spin_state_e;

  // Galois right-shift step; a non-zero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/roulette_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the spinner's entropy source.
// Ports:
//   clk     - system clock
//   reset_n - synchronous active-low reset, loads seed (0 replaced by 1)
//   seed    - reset value
//   state   - current LFSR state, advances every cycle
module roulette_lfsr16
  import roulette_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q, state_d, seed_eff;

  always_comb begin
    // An all-zero seed would lock the LFSR, so substitute 1.
    seed_eff = (seed == '0) ? LFSR_W'(1) : seed;
    state_d  = lfsr_next(state_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= seed_eff;
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/roulette_wheel_spinner.sv
// Roulette wheel spinner: on a spin_req rising edge runs a decelerating
// animation (step interval grows by STEP_INC each step) and then latches a
// reduced LFSR sample as the final result with a one-cycle valid pulse.
// Ports:
//   clk          - system clock
//   reset_n      - synchronous active-low reset
//   spin_req     - level spin request, rising edge starts a spin when idle
//   randnum      - latched final result, held until the next result
//   result_valid - one-cycle pulse when randnum updates
//   busy         - high while spinning
//   spin_display - animated value, equals randnum when idle
module roulette_wheel_spinner
  import roulette_pkg::*;
#(
  parameter int unsigned       NUM_W     = DEF_NUM_W,
  parameter int unsigned       MAX_NUM   = DEF_MAX_NUM,
  parameter int unsigned       CNT_W     = 24,
  parameter int unsigned       START_DIV = 2_500_000,
  parameter int unsigned       STEP_INC  = 500_000,
  parameter int unsigned       END_DIV   = 12_500_000,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spin_req,
  output logic [NUM_W-1:0] randnum,
  output logic             result_valid,
  output logic             busy,
  output logic [NUM_W-1:0] spin_display
);

  spin_state_e       state_q, state_d;
  logic [CNT_W-1:0]  tick_q, tick_d;
  logic [CNT_W-1:0]  interval_q, interval_d;
  logic [NUM_W-1:0]  randnum_q, randnum_d;
  logic [NUM_W-1:0]  display_q, display_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              req_prev_q, req_prev_d;

  logic [LFSR_W-1:0] lfsr_state;
  logic [NUM_W-1:0]  reduced;
  logic [CNT_W:0]    interval_next;
  logic              spin_edge, step_hit, last_step;

  roulette_lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (SEED),
    .state   (lfsr_state)
  );

  // Fold the raw low bits into 0..MAX_NUM with a single subtraction.
  function automatic logic [NUM_W-1:0] reduce(input logic [LFSR_W-1:0] s);
    logic [NUM_W-1:0] r;
    r = s[NUM_W-1:0];
    if (r > NUM_W'(MAX_NUM)) r = r - NUM_W'(MAX_NUM + 1);
    return r;
  endfunction

  always_comb begin
    reduced       = reduce(lfsr_state);
    spin_edge     = spin_req & ~req_prev_q;
    // One extra bit so the end-of-spin compare cannot be fooled by overflow.
    interval_next = {1'b0, interval_q} + (CNT_W+1)'(STEP_INC);
    step_hit      = (tick_q == interval_q - CNT_W'(1));
    last_step     = interval_next > (CNT_W+1)'(END_DIV);

    state_d    = state_q;
    tick_d     = tick_q;
    interval_d = interval_q;
    randnum_d  = randnum_q;
    display_d  = display_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    req_prev_d = spin_req;

    case (state_q)
      IDLE: begin
        if (spin_edge) begin
          state_d    = SPIN;
          busy_d     = 1'b1;
          tick_d     = '0;
          interval_d = CNT_W'(START_DIV);
        end
      end
      SPIN: begin
        if (step_hit) begin
          tick_d     = '0;
          display_d  = reduced;
          interval_d = interval_next[CNT_W-1:0];
          if (last_step) begin
            randnum_d = reduced;
            valid_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      interval_q <= CNT_W'(START_DIV);
      randnum_q  <= '0;
      display_q  <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      interval_q <= interval_d;
      randnum_q  <= randnum_d;
      display_q  <= display_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      req_prev_q <= req_prev_d;
    end
  end

  assign randnum      = randnum_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign spin_display = display_q;

endmodule

// File: tb/tb_roulette_wheel_spinner.sv
// Bench for roulette_wheel_spinner: two instances share the stimulus, one with
// a short growing-interval spin (2,1,4) and one degenerate (5,1,3), both with
// MAX_NUM=17. A reference model computes spin lengths and step instants from
// the interval series and pushes expected results into per-instance queues.
module tb_roulette_wheel_spinner;

  localparam int          MAXN   = 17;
  localparam logic [15:0] SEED_V = 16'hACE1;
  localparam int          INC    = 1;
  localparam int          START0 = 2;
  localparam int          END0   = 4;
  localparam int          START1 = 5;
  localparam int          END1   = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic spin_req;

  logic [4:0] rn0, dp0, rn1, dp1;
  logic       rv0, bz0, rv1, bz1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  roulette_wheel_spinner #(
    .NUM_W(5), .MAX_NUM(17), .CNT_W(24),
    .START_DIV(START0), .STEP_INC(INC), .END_DIV(END0), .SEED(SEED_V)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spin_req(spin_req),
    .randnum(rn0), .result_valid(rv0), .busy(bz0), .spin_display(dp0)
  );

  roulette_wheel_spinner #(
    .NUM_W(5), .MAX_NUM(17), .CNT_W(24),
    .START_DIV(START1), .STEP_INC(INC), .END_DIV(END1), .SEED(SEED_V)
  ) dut_d (
    .clk(clk), .reset_n(reset_n), .spin_req(spin_req),
    .randnum(rn1), .result_valid(rv1), .busy(bz1), .spin_display(dp1)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr;
  bit          m_busy  [2];
  bit          m_prev  [2];
  bit          m_valid [2];
  int          m_el    [2];
  logic [4:0]  m_disp  [2];
  logic [4:0]  m_rand  [2];
  logic [4:0]  q0 [$];
  logic [4:0]  q1 [$];
  int          pulses [2];
  bit          seen_even = 0, seen_odd = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [4:0] ref_reduce(input logic [15:0] x);
    int v;
    v = int'(x) % 32;
    if (v > MAXN) v = v - (MAXN + 1);
    return 5'(v);
  endfunction

  // Elapsed cycle counts at which a step lands: running sums of the intervals.
  function automatic bit is_step(input int s, input int e, input int el);
    int t, iv;
    t = 0; iv = s;
    do begin
      t += iv;
      if (t == el) return 1'b1;
      iv += INC;
    end while (iv <= e);
    return 1'b0;
  endfunction

  function automatic int spin_len(input int s, input int e);
    int t, iv;
    t = 0; iv = s;
    do begin
      t += iv;
      iv += INC;
    end while (iv <= e);
    return t;
  endfunction

  initial begin
    m_lfsr = SEED_V;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_prev[i] = 0; m_valid[i] = 0; m_el[i] = 0;
      m_disp[i] = '0; m_rand[i] = '0; pulses[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        int s, e;
        s = (i == 0) ? START0 : START1;
        e = (i == 0) ? END0 : END1;
        if (!reset_n) begin
          m_busy[i] = 0; m_prev[i] = 0; m_valid[i] = 0; m_el[i] = 0;
          m_disp[i] = '0; m_rand[i] = '0;
        end else begin
          m_valid[i] = 0;
          if (m_busy[i]) begin
            m_el[i]++;
            if (is_step(s, e, m_el[i])) m_disp[i] = ref_reduce(m_lfsr);
            if (m_el[i] == spin_len(s, e)) begin
              m_rand[i]  = m_disp[i];
              m_valid[i] = 1;
              m_busy[i]  = 0;
              if (i == 0) q0.push_back(m_disp[i]);
              else        q1.push_back(m_disp[i]);
            end
          end else if (spin_req && !m_prev[i]) begin
            m_busy[i] = 1;
            m_el[i]   = 0;
          end
          m_prev[i] = spin_req;
        end
      end
      if (!reset_n) m_lfsr = SEED_V;
      else          m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int i, input logic [4:0] rn, input logic rv, input logic bz,
                     input logic [4:0] dp, input logic [15:0] lf);
    logic [4:0] e;
    chk($sformatf("valid%0d", i), 32'(rv), 32'(m_valid[i]));
    chk($sformatf("busy%0d", i), 32'(bz), 32'(m_busy[i]));
    chk($sformatf("display%0d", i), 32'(dp), 32'(m_disp[i]));
    chk($sformatf("randnum%0d", i), 32'(rn), 32'(m_rand[i]));
    chk($sformatf("lfsr%0d", i), 32'(lf), 32'(m_lfsr));
    if (rv) begin
      pulses[i]++;
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected%0d: got randnum %0d expected no result", i, rn);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sb_result%0d", i), 32'(rn), 32'(e));
      end
      chk($sformatf("range%0d", i), 32'(rn <= 5'(MAXN)), 32'd1);
      if (i == 0) begin
        if (rn[0]) seen_odd = 1; else seen_even = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, rn0, rv0, bz0, dp0, dut.lfsr_state);
      mon(1, rn1, rv1, bz1, dp1, dut_d.lfsr_state);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Raise spin_req before edge N and measure negedges until each valid pulse.
  task automatic timed_spin(input string tag);
    int n, n1;
    n = 0; n1 = 0;
    spin_req = 1'b0;
    @(negedge clk);
    spin_req = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_busy_on"}, 32'(bz0), 32'd1);
      if (rv1 && n1 == 0) n1 = n;
    end while (!rv0 && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'd10);
    chk({tag, "_latency_d"}, 32'(n1), 32'd6);
    @(negedge clk);
    chk({tag, "_busy_off"}, 32'(bz0), 32'd0);
    chk({tag, "_pulse_clear"}, 32'(rv0), 32'd0);
  endtask

  initial begin
    int p0, p1, cyc, pbase;
    reset_n  = 1'b0;
    spin_req = 1'b0;
    idle_cycles(2);
    chk("rst_randnum", 32'(rn0), 32'd0);
    chk("rst_display", 32'(dp0), 32'd0);
    chk("rst_valid", 32'(rv0), 32'd0);
    chk("rst_busy", 32'(bz0), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr_state), 32'h0000ACE1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("lfsr_1", 32'(dut.lfsr_state), 32'h0000E270);
    @(negedge clk);
    chk("lfsr_2", 32'(dut.lfsr_state), 32'h00007138);

    timed_spin("timing");
    idle_cycles(3);

    // Extra edges while spinning and a held-high request afterwards.
    p0 = pulses[0]; p1 = pulses[1];
    spin_req = 1'b0; @(negedge clk);
    spin_req = 1'b1; @(negedge clk);
    spin_req = 1'b0; @(negedge clk);
    spin_req = 1'b1; @(negedge clk);
    spin_req = 1'b0; @(negedge clk);
    spin_req = 1'b1;
    idle_cycles(30);
    chk("ignored_edges", 32'(pulses[0] - p0), 32'd1);
    chk("ignored_edges_d", 32'(pulses[1] - p1), 32'd1);
    chk("held_high_idle", 32'(bz0), 32'd0);

    // Reset lands on edge N+4.
    p0 = pulses[0]; p1 = pulses[1];
    spin_req = 1'b0; @(negedge clk);
    spin_req = 1'b1;
    idle_cycles(4);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bz0), 32'd0);
    chk("midrst_randnum", 32'(rn0), 32'd0);
    chk("midrst_lfsr", 32'(dut.lfsr_state), 32'h0000ACE1);
    reset_n  = 1'b1;
    spin_req = 1'b0;
    idle_cycles(15);
    chk("midrst_no_pulse", 32'(pulses[0] - p0), 32'd0);
    chk("midrst_no_pulse_d", 32'(pulses[1] - p1), 32'd0);
    timed_spin("after_rst");

    // Random toggling with rare resets until 200 results from the main instance.
    pbase = pulses[0];
    cyc = 0;
    while ((pulses[0] - pbase) < 200 && cyc < 20000) begin
      spin_req = 1'($urandom_range(0, 1));
      reset_n  = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("random_spin_count", 32'((pulses[0] - pbase) >= 200), 32'd1);
    reset_n  = 1'b1;
    spin_req = 1'b0;
    cyc = 0;
    while ((bz0 || bz1) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_idle", 32'(bz0 | bz1), 32'd0);
    @(negedge clk);
    chk("sb_drain0", 32'(q0.size()), 32'd0);
    chk("sb_drain1", 32'(q1.size()), 32'd0);
    chk("seen_even", 32'(seen_even), 32'd1);
    chk("seen_odd", 32'(seen_odd), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/roulette_wheel_spinner.md
Name: roulette_wheel_spinner

Overview:
Upstream stage of the even/odd roulette game. It produces the 5-bit random result consumed as `randnum` by the game FSM. A free-running 16-bit LFSR gives entropy. A spin request runs a decelerating "wheel" animation that steps a display value at growing intervals, then latches a final result with a one-cycle valid pulse. The result is held stable until the next spin, so the game FSM can sample it at any later time.

Parameters:
- NUM_W, 5, result width in bits.
- MAX_NUM, 31, largest legal result (inclusive); must be ≤ 2^NUM_W−1.
- CNT_W, 24, width of the tick counter and the interval register.
- START_DIV, 2_500_000, clock cycles per step at spin start (must be ≥1).
- STEP_INC, 500_000, cycles added to the interval after each step.
- END_DIV, 12_500_000, spin ends once the interval exceeds this value.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- clk, in, 1, system clock (CLOCK_50).
- reset_n, in, 1, reset, synchronous, active-low.
- spin_req, in, 1, spin request, already synchronised and active-high; level input, edge-detected internally.
- randnum, out, NUM_W, latched final result, held until the next result.
- result_valid, out, 1, one-cycle pulse when randnum updates.
- busy, out, 1, high while spinning.
- spin_display, out, NUM_W, animated value for the HEX display; equals randnum when idle.

Behaviour:
- All outputs are registered.
- Reset (reset_n low at a posedge): state IDLE, randnum=0, spin_display=0, result_valid=0, busy=0, tick counter=0, interval=START_DIV, LFSR=SEED (or 1 if SEED is 0), spin_req edge register=0.
- Reset mid-spin aborts the spin with no valid pulse.
- LFSR:
  - 16-bit Galois, right-shift, taps mask 16'hB400.
  - next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances every cycle in every state; never reaches 0.
- Reduce function: r = lfsr[NUM_W-1:0]; if r > MAX_NUM, then r − (MAX_NUM+1). This is purely combinational.
- States:
  - IDLE: a rising edge of spin_req (sampled high, previous sample low) moves to SPIN at that edge. On the same edge: busy<=1, tick<=0, interval<=START_DIV.
  - SPIN: tick increments each cycle. When tick == interval−1, a step occurs:
    - tick<=0;
    - spin_display<=reduce(lfsr);
    - interval<=interval+STEP_INC.
  - SPIN exit: if interval+STEP_INC > END_DIV at that step, the step is final. On the final step:
    - randnum<=reduce(lfsr) (same value as spin_display);
    - result_valid<=1, busy<=0;
    - state<=IDLE.
- result_valid is high for exactly one cycle and clears on the next edge.
- Spin length: the interval sequence is START_DIV, START_DIV+STEP_INC, …, up to the largest value ≤ END_DIV. Total SPIN cycles = sum of that sequence. With START_DIV=2, STEP_INC=1, END_DIV=4, this is 2+3+4 = 9 cycles, i.e. result_valid is high in the cycle after edge N+9, where N is the accepting edge.
- If START_DIV > END_DIV, exactly one step of START_DIV cycles occurs, then the result latches.
- spin_req edges during SPIN are ignored; they are neither queued nor restart the spin. Holding spin_req high does not retrigger; a new low→high edge is required.
- A spin_req rising edge arriving on the same cycle as the final step is ignored; its edge register still updates.
- interval arithmetic is CNT_W bits wide. Parameters are constrained so that END_DIV+STEP_INC < 2^CNT_W; there is no wrap.
- When idle, spin_display is held equal to randnum.

Decomposition:
- Shared package roulette_pkg holds:
  - state encoding (IDLE=1'b0, SPIN=1'b1);
  - LFSR_TAPS=16'hB400 and LFSR_W=16;
  - default NUM_W=5 and MAX_NUM=31, shared with roulette_guessEvenOdd so randnum widths match.
- One sub-module: roulette_lfsr16 (clk, reset_n, seed → 16-bit state, always enabled).
- The spinner FSM, reduce function and counters stay in roulette_wheel_spinner.

Test Plan:
- Reset check: hold reset_n low for 2 cycles → randnum=0, spin_display=0, result_valid=0, busy=0. LFSR reads 16'hACE1, then 16'hE270 and 16'h7138 on the next two cycles after release.
- Timing check (START_DIV=2, STEP_INC=1, END_DIV=4): raise spin_req at edge N →
  - busy=1 from N;
  - spin_display changes at N+2, N+5 and N+9;
  - result_valid is a single pulse after N+9, with randnum equal to the N+9 spin_display value;
  - busy=0 after N+9.
- Ignored edges: toggle spin_req low/high twice during SPIN, and hold it high after completion → exactly one result_valid pulse, with no new spin until the next low→high edge.
- Reset mid-spin: assert reset_n low at N+4 → no result_valid, randnum=0, busy=0, LFSR reloads SEED; a fresh spin afterwards behaves exactly as in the timing check.
- Range reduction (NUM_W=5, MAX_NUM=17): run 200 spins → every randnum ≤ 17, and both even and odd values are observed.
- Degenerate case (START_DIV=5, END_DIV=3): one step, result_valid after N+5, with randnum equal to reduce(lfsr) sampled at that edge.
